multiply_accumulate_pipeline: RTL and testbench

//  Multithreaded multiply-accumulate accelerator. Successor to the fixed signed/unsigned multiplier pipeline.

---
 rtl/multiply_accumulate_pkg.sv | 18 +
 rtl/multiply_accumulate_pipeline_thread_context_store.sv | 67 ++++++
 rtl/multiply_accumulate_pipeline.sv | 186 ++++++++++++++++++
 tb/tb_multiply_accumulate_pipeline.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_accumulate_pkg.sv
// Shared definitions for the multithreaded multiply-accumulate pipeline.
//   CFG_OFF_MODE / CFG_OFF_CLEAR : word offsets inside the two-word config block
//   MODE_SIGNED / MODE_ACCUM     : bit positions of the mode flags in config_data
//   mode_t                       : per-thread mode (accumulate, signed)
package multiply_accumulate_pkg;

   localparam int CFG_OFF_MODE  = 0;
   localparam int CFG_OFF_CLEAR = 1;

   localparam int MODE_SIGNED = 0;
   localparam int MODE_ACCUM  = 1;

   typedef struct packed {
      logic accum;
      logic is_signed;
   } mode_t;

endpackage

// File: rtl/multiply_accumulate_pipeline_thread_context_store.sv
// Per-thread context register file (operands A/B, mode, pending-clear).
// Written and read at the index of the slot counter. The read is registered,
// so a write in a thread's slot is only seen at that thread's next slot.
//   clock, reset_n           : clock, async active-low reset
//   slot                     : current thread slot
//   a_wren/a_data, b_wren/b_data : operand writes for the current slot
//   mode_wren/mode_data      : mode write for the current slot
//   clear_set                : arm pending-clear for the current slot
//   issue_*                  : context issued by the current slot (registered)
module thread_context_store
   import multiply_accumulate_pkg::*;
#(
   parameter int WORD_WIDTH   = 36,
   parameter int THREAD_COUNT = 8,
   parameter int THREAD_WIDTH = $clog2(THREAD_COUNT)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [THREAD_WIDTH-1:0] slot,
   input  logic                    a_wren,
   input  logic [WORD_WIDTH-1:0]   a_data,
   input  logic                    b_wren,
   input  logic [WORD_WIDTH-1:0]   b_data,
   input  logic                    mode_wren,
   input  mode_t                   mode_data,
   input  logic                    clear_set,
   output logic [WORD_WIDTH-1:0]   issue_a,
   output logic [WORD_WIDTH-1:0]   issue_b,
   output mode_t                   issue_mode,
   output logic                    issue_clear,
   output logic [THREAD_WIDTH-1:0] issue_thread
);

   logic [WORD_WIDTH-1:0] a_mem     [THREAD_COUNT];
   logic [WORD_WIDTH-1:0] b_mem     [THREAD_COUNT];
   mode_t                 mode_mem  [THREAD_COUNT];
   logic                  clear_mem [THREAD_COUNT];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < THREAD_COUNT; i++) begin
            a_mem[i]     <= '0;
            b_mem[i]     <= '0;
            mode_mem[i]  <= '0;
            clear_mem[i] <= 1'b0;
         end
         issue_a      <= '0;
         issue_b      <= '0;
         issue_mode   <= '0;
         issue_clear  <= 1'b0;
         issue_thread <= '0;
      end else begin
         issue_a      <= a_mem[slot];
         issue_b      <= b_mem[slot];
         issue_mode   <= mode_mem[slot];
         issue_clear  <= clear_mem[slot];
         issue_thread <= slot;
         if (a_wren)    a_mem[slot]    <= a_data;
         if (b_wren)    b_mem[slot]    <= b_data;
         if (mode_wren) mode_mem[slot] <= mode_data;
         // The issue consumes the pending clear in this same slot; a clear
         // written now re-arms it for the next issue, so the set simply wins.
         clear_mem[slot] <= clear_set;
      end
   end

endmodule

// File: rtl/multiply_accumulate_pipeline.sv
// Multithreaded multiply-accumulate pipeline. Depth equals THREAD_COUNT, so a
// thread's result returns exactly when its slot comes around again.
//   clock, reset_n                 : clock, async active-low reset
//   config_addr/data/wren          : config block (mode word, clear word)
//   A/A_wren, B/B_wren             : operand writes for the current thread
//   R_low, R_high                  : 2W-bit result split in halves
//   R_overflow                     : accumulate add overflowed for this result
//   R_thread                       : thread owning the current result
module multiply_accumulate_pipeline
   import multiply_accumulate_pkg::*;
#(
   parameter int WORD_WIDTH        = 36,
   parameter int THREAD_COUNT      = 8,
   parameter int CONFIG_ADDR       = 0,
   parameter int CONFIG_ADDR_WIDTH = 10
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [CONFIG_ADDR_WIDTH-1:0]    config_addr,
   input  logic [1:0]                      config_data,
   input  logic                            config_wren,
   input  logic [WORD_WIDTH-1:0]           A,
   input  logic                            A_wren,
   input  logic [WORD_WIDTH-1:0]           B,
   input  logic                            B_wren,
   output logic [WORD_WIDTH-1:0]           R_low,
   output logic [WORD_WIDTH-1:0]           R_high,
   output logic                            R_overflow,
   output logic [$clog2(THREAD_COUNT)-1:0] R_thread
);

   localparam int TW    = $clog2(THREAD_COUNT);
   localparam int PW    = 2 * WORD_WIDTH;
   localparam int N_IN  = THREAD_COUNT / 2 - 1;
   localparam int N_OUT = THREAD_COUNT / 2;
   localparam int LAST  = N_OUT - 2;

   localparam logic [CONFIG_ADDR_WIDTH-1:0] MODE_ADDR  = CONFIG_ADDR_WIDTH'(CONFIG_ADDR + CFG_OFF_MODE);
   localparam logic [CONFIG_ADDR_WIDTH-1:0] CLEAR_ADDR = CONFIG_ADDR_WIDTH'(CONFIG_ADDR + CFG_OFF_CLEAR);

   logic [TW-1:0] slot;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                            slot <= '0;
      else if (slot == TW'(THREAD_COUNT - 1))  slot <= '0;
      else                                     slot <= slot + TW'(1);
   end

   logic  mode_wren, clear_set;
   mode_t mode_data;

   always_comb begin
      mode_wren           = config_wren && (config_addr == MODE_ADDR);
      clear_set           = config_wren && (config_addr == CLEAR_ADDR);
      mode_data.accum     = config_data[MODE_ACCUM];
      mode_data.is_signed = config_data[MODE_SIGNED];
   end

   logic [WORD_WIDTH-1:0] issue_a, issue_b;
   mode_t                 issue_mode;
   logic                  issue_clear;
   logic [TW-1:0]         issue_thread;

   thread_context_store #(
      .WORD_WIDTH   (WORD_WIDTH),
      .THREAD_COUNT (THREAD_COUNT),
      .THREAD_WIDTH (TW)
   ) u_context (
      .clock        (clock),
      .reset_n      (reset_n),
      .slot         (slot),
      .a_wren       (A_wren),
      .a_data       (A),
      .b_wren       (B_wren),
      .b_data       (B),
      .mode_wren    (mode_wren),
      .mode_data    (mode_data),
      .clear_set    (clear_set),
      .issue_a      (issue_a),
      .issue_b      (issue_b),
      .issue_mode   (issue_mode),
      .issue_clear  (issue_clear),
      .issue_thread (issue_thread)
   );

   // Input stages ahead of the multiplier.
   logic [WORD_WIDTH-1:0] in_a      [N_IN];
   logic [WORD_WIDTH-1:0] in_b      [N_IN];
   mode_t                 in_mode   [N_IN];
   logic                  in_clear  [N_IN];
   logic [TW-1:0]         in_thread [N_IN];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_IN; i++) begin
            in_a[i]      <= '0;
            in_b[i]      <= '0;
            in_mode[i]   <= '0;
            in_clear[i]  <= 1'b0;
            in_thread[i] <= '0;
         end
      end else begin
         in_a[0]      <= issue_a;
         in_b[0]      <= issue_b;
         in_mode[0]   <= issue_mode;
         in_clear[0]  <= issue_clear;
         in_thread[0] <= issue_thread;
         for (int i = 1; i < N_IN; i++) begin
            in_a[i]      <= in_a[i-1];
            in_b[i]      <= in_b[i-1];
            in_mode[i]   <= in_mode[i-1];
            in_clear[i]  <= in_clear[i-1];
            in_thread[i] <= in_thread[i-1];
         end
      end
   end

   // Unregistered multiplier so the surrounding stages can be retimed into it.
   // Sign-extending to 2W and keeping the low 2W bits of an unsigned product
   // gives the two's-complement product, so one multiplier serves both modes.
   logic [PW-1:0] mul_a, mul_b, product;

   always_comb begin
      mul_a   = {{WORD_WIDTH{in_mode[N_IN-1].is_signed & in_a[N_IN-1][WORD_WIDTH-1]}}, in_a[N_IN-1]};
      mul_b   = {{WORD_WIDTH{in_mode[N_IN-1].is_signed & in_b[N_IN-1][WORD_WIDTH-1]}}, in_b[N_IN-1]};
      product = mul_a * mul_b;
   end

   // Output stages; the last one is the result register with the accumulate add.
   logic [PW-1:0] o_p      [N_OUT-1];
   mode_t         o_mode   [N_OUT-1];
   logic          o_clear  [N_OUT-1];
   logic [TW-1:0] o_thread [N_OUT-1];
   logic [PW-1:0] acc_mem  [THREAD_COUNT];

   logic [PW-1:0] acc_base, result;
   logic [PW:0]   acc_sum;
   logic          overflow;

   always_comb begin
      acc_base = o_clear[LAST] ? '0 : acc_mem[o_thread[LAST]];
      acc_sum  = {1'b0, acc_base} + {1'b0, o_p[LAST]};
      result   = o_p[LAST];
      overflow = 1'b0;
      if (o_mode[LAST].accum) begin
         result = acc_sum[PW-1:0];
         if (o_mode[LAST].is_signed)
            overflow = (acc_base[PW-1] == o_p[LAST][PW-1]) && (result[PW-1] != acc_base[PW-1]);
         else
            overflow = acc_sum[PW];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_OUT - 1; i++) begin
            o_p[i]      <= '0;
            o_mode[i]   <= '0;
            o_clear[i]  <= 1'b0;
            o_thread[i] <= '0;
         end
         for (int i = 0; i < THREAD_COUNT; i++) acc_mem[i] <= '0;
         R_low      <= '0;
         R_high     <= '0;
         R_overflow <= 1'b0;
         R_thread   <= '0;
      end else begin
         o_p[0]      <= product;
         o_mode[0]   <= in_mode[N_IN-1];
         o_clear[0]  <= in_clear[N_IN-1];
         o_thread[0] <= in_thread[N_IN-1];
         for (int i = 1; i < N_OUT - 1; i++) begin
            o_p[i]      <= o_p[i-1];
            o_mode[i]   <= o_mode[i-1];
            o_clear[i]  <= o_clear[i-1];
            o_thread[i] <= o_thread[i-1];
         end
         acc_mem[o_thread[LAST]] <= result;
         R_low      <= result[WORD_WIDTH-1:0];
         R_high     <= result[PW-1:WORD_WIDTH];
         R_overflow <= overflow;
         R_thread   <= o_thread[LAST];
      end
   end

endmodule

// File: tb/tb_multiply_accumulate_pipeline.sv
module tb_multiply_accumulate_pipeline;

   localparam int W     = 8;
   localparam int T     = 8;
   localparam int CA    = 'h020;
   localparam int DEPTH = 1024;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [9:0] config_addr;
   logic [1:0] config_data;
   logic       config_wren;
   logic [7:0] A, B;
   logic       A_wren, B_wren;
   logic [7:0] R_low, R_high;
   logic       R_overflow;
   logic [2:0] R_thread;

   multiply_accumulate_pipeline #(
      .WORD_WIDTH        (W),
      .THREAD_COUNT      (T),
      .CONFIG_ADDR       (CA),
      .CONFIG_ADDR_WIDTH (10)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .config_addr (config_addr),
      .config_data (config_data),
      .config_wren (config_wren),
      .A           (A),
      .A_wren      (A_wren),
      .B           (B),
      .B_wren      (B_wren),
      .R_low       (R_low),
      .R_high      (R_high),
      .R_overflow  (R_overflow),
      .R_thread    (R_thread)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Behavioural model: per-thread architectural state.
   int m_a [T], m_b [T], m_mode [T], m_clr [T], m_acc [T];

   logic [15:0] exp_r [DEPTH];
   logic [2:0]  exp_thr [DEPTH];
   logic        exp_ov [DEPTH];
   logic [15:0] obs_r [DEPTH];
   logic [2:0]  obs_thr [DEPTH];
   logic        obs_ov [DEPTH];

   function automatic int sx8(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic int sx16(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < T; i++) begin
         m_a[i] = 0; m_b[i] = 0; m_mode[i] = 0; m_clr[i] = 0; m_acc[i] = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         exp_r[i] = 16'h0; exp_thr[i] = 3'd0; exp_ov[i] = 1'b0;
      end
      cyc = 0;
   endtask

   // One clock cycle: record outputs, issue the thread in the model, drive writes.
   task automatic tick(input bit a_en, input int a, input bit b_en, input int b,
                       input bit c_en, input int addr, input int data);
      int th, p, base, sum, r, ov, ss;
      if (cyc + T >= DEPTH) begin
         $display("FAIL cycle_budget got cycle=%0d required below %0d", cyc, DEPTH - T);
         failures++;
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "cycle budget exceeded");
      end
      obs_r[cyc]   = {R_high, R_low};
      obs_thr[cyc] = R_thread;
      obs_ov[cyc]  = R_overflow;

      th = cyc % T;
      if ((m_mode[th] & 1) != 0) p = (sx8(m_a[th]) * sx8(m_b[th])) & 'hFFFF;
      else                       p = m_a[th] * m_b[th];
      if ((m_mode[th] & 2) != 0) begin
         base = (m_clr[th] != 0) ? 0 : m_acc[th];
         sum  = base + p;
         r    = sum & 'hFFFF;
         if ((m_mode[th] & 1) != 0) begin
            ss = sx16(base) + sx16(p);
            ov = (ss > 32767 || ss < -32768) ? 1 : 0;
         end else begin
            ov = (sum > 'hFFFF) ? 1 : 0;
         end
      end else begin
         r  = p;
         ov = 0;
      end
      m_acc[th] = r;
      m_clr[th] = 0;
      exp_r[cyc + T]   = 16'(r);
      exp_thr[cyc + T] = 3'(th);
      exp_ov[cyc + T]  = ov[0];

      A_wren = a_en;  A = 8'(a);
      B_wren = b_en;  B = 8'(b);
      config_wren = c_en; config_addr = 10'(addr); config_data = 2'(data);
      if (a_en) m_a[th] = a & 'hFF;
      if (b_en) m_b[th] = b & 'hFF;
      if (c_en) begin
         if (addr == CA)          m_mode[th] = data & 3;
         else if (addr == CA + 1) m_clr[th] = 1;
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic to_slot(input int th);
      while (cyc % T != th) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      int s;
      A = 0; B = 0; A_wren = 0; B_wren = 0;
      config_addr = 0; config_data = 0; config_wren = 0;
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({R_high, R_low, R_overflow, R_thread} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs got r=%h ovf=%0d thr=%0d want 0", {R_high, R_low}, R_overflow, R_thread);
      end
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
      reset_model();
      s = cyc;
      idle(T + 2);
      checks++;
      if ({obs_r[T], obs_thr[T]} !== {16'h0, 3'd0}) begin
         failures++;
         $display("FAIL reset_first_result got r=%h thr=%0d want r=0000 thr=0", obs_r[T], obs_thr[T]);
      end
      checks++;
      if (obs_thr[T + 1] !== 3'd1) begin
         failures++;
         $display("FAIL reset_slot_order got thr=%0d want thr=1", obs_thr[T + 1]);
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL reset_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_basic_multiply();
      int s, c0;
      s = cyc;
      to_slot(0);
      c0 = cyc;
      tick(1, 3, 1, 5, 0, 0, 0);
      idle(16);
      checks++;
      if ({obs_r[c0 + 16], obs_thr[c0 + 16], obs_ov[c0 + 16]} !== {16'h000F, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL basic_multiply got r=%h thr=%0d ovf=%0d want r=000f thr=0 ovf=0",
                  obs_r[c0 + 16], obs_thr[c0 + 16], obs_ov[c0 + 16]);
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL basic_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_signed_unsigned();
      int s, c0;
      s = cyc;
      to_slot(2);
      c0 = cyc;
      tick(1, 'hFE, 1, 3, 1, CA, 1);
      idle(7);
      tick(0, 0, 0, 0, 1, CA, 0);
      idle(16);
      checks++;
      if ({obs_r[c0 + 16], obs_thr[c0 + 16]} !== {16'hFFFA, 3'd2}) begin
         failures++;
         $display("FAIL signed_product got r=%h thr=%0d want r=fffa thr=2", obs_r[c0 + 16], obs_thr[c0 + 16]);
      end
      checks++;
      if ({obs_r[c0 + 24], obs_thr[c0 + 24]} !== {16'h02FA, 3'd2}) begin
         failures++;
         $display("FAIL unsigned_product got r=%h thr=%0d want r=02fa thr=2", obs_r[c0 + 24], obs_thr[c0 + 24]);
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL signed_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_accumulate_clear();
      int s, c0;
      logic [15:0] want [4];
      want[0] = 16'h0100; want[1] = 16'h0200; want[2] = 16'h0300; want[3] = 16'h0100;
      s = cyc;
      to_slot(5);
      c0 = cyc;
      tick(1, 'h10, 1, 'h10, 1, CA, 2);
      idle(23);
      tick(0, 0, 0, 0, 1, CA + 1, 3);
      idle(17);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({obs_r[c0 + 16 + 8 * k], obs_thr[c0 + 16 + 8 * k]} !== {want[k], 3'd5}) begin
            failures++;
            $display("FAIL accumulate_step%0d got r=%h thr=%0d want r=%h thr=5",
                     k, obs_r[c0 + 16 + 8 * k], obs_thr[c0 + 16 + 8 * k], want[k]);
         end
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL accumulate_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_overflow();
      int s, c0;
      s = cyc;
      to_slot(1);
      c0 = cyc;
      tick(1, 'hFF, 1, 'hFF, 1, CA, 0);
      idle(7);
      tick(0, 0, 1, 1, 1, CA, 2);
      idle(7);
      tick(1, 'h10, 1, 'h10, 0, 0, 0);
      idle(7);
      tick(1, 'h80, 1, 'h80, 1, CA, 1);
      idle(7);
      tick(1, 'h82, 0, 0, 1, CA, 3);
      idle(7);
      tick(1, 'h10, 1, 'h10, 0, 0, 0);
      idle(16);
      checks++;
      if ({obs_r[c0 + 24], obs_ov[c0 + 24]} !== {16'hFF00, 1'b0}) begin
         failures++;
         $display("FAIL unsigned_preload got r=%h ovf=%0d want r=ff00 ovf=0", obs_r[c0 + 24], obs_ov[c0 + 24]);
      end
      checks++;
      if ({obs_r[c0 + 32], obs_ov[c0 + 32]} !== {16'h0000, 1'b1}) begin
         failures++;
         $display("FAIL unsigned_overflow got r=%h ovf=%0d want r=0000 ovf=1", obs_r[c0 + 32], obs_ov[c0 + 32]);
      end
      checks++;
      if ({obs_r[c0 + 48], obs_ov[c0 + 48]} !== {16'h7F00, 1'b0}) begin
         failures++;
         $display("FAIL signed_preload got r=%h ovf=%0d want r=7f00 ovf=0", obs_r[c0 + 48], obs_ov[c0 + 48]);
      end
      checks++;
      if ({obs_r[c0 + 56], obs_ov[c0 + 56], obs_thr[c0 + 56]} !== {16'h8000, 1'b1, 3'd1}) begin
         failures++;
         $display("FAIL signed_overflow got r=%h ovf=%0d thr=%0d want r=8000 ovf=1 thr=1",
                  obs_r[c0 + 56], obs_ov[c0 + 56], obs_thr[c0 + 56]);
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL overflow_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_interleave();
      int s, sel, addr;
      s = cyc;
      for (int i = 0; i < 240; i++) begin
         sel = int'($urandom_range(0, 7));
         if (sel == 0)      addr = CA;
         else if (sel == 1) addr = CA + 1;
         else if (sel == 2) addr = CA + 2 + int'($urandom_range(0, 20));
         else               addr = -1;
         tick($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
              addr >= 0, (addr >= 0) ? addr : 0, int'($urandom_range(0, 3)));
      end
      idle(T);
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL interleave_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   task automatic test_reset_mid_accumulation();
      int s;
      for (int th = 0; th < T; th++) tick(1, 'h33, 1, 'h21, 1, CA, 2);
      idle(T + 3);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({R_high, R_low, R_overflow, R_thread} !== 20'h0) begin
         failures++;
         $display("FAIL async_reset_outputs got r=%h ovf=%0d thr=%0d want 0", {R_high, R_low}, R_overflow, R_thread);
      end
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
      reset_model();
      s = cyc;
      for (int th = 0; th < T; th++) tick(1, 1, 1, 1, 1, CA, 2);
      idle(3 * T);
      checks++;
      if ({obs_r[T], obs_thr[T], obs_ov[T]} !== {16'h0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_first got r=%h thr=%0d ovf=%0d want r=0000 thr=0 ovf=0",
                  obs_r[T], obs_thr[T], obs_ov[T]);
      end
      for (int th = 0; th < T; th++) begin
         checks++;
         if ({obs_r[2 * T + th], obs_thr[2 * T + th]} !== {16'h0001, 3'(th)}) begin
            failures++;
            $display("FAIL post_reset_acc thread=%0d got r=%h thr=%0d want r=0001 thr=%0d",
                     th, obs_r[2 * T + th], obs_thr[2 * T + th], th);
         end
      end
      for (int m = s; m < cyc; m++) begin
         checks++;
         if (obs_r[m] !== exp_r[m] || obs_thr[m] !== exp_thr[m] || obs_ov[m] !== exp_ov[m]) begin
            failures++;
            $display("FAIL post_reset_model cycle=%0d got r=%h thr=%0d ovf=%0d want r=%h thr=%0d ovf=%0d",
                     m, obs_r[m], obs_thr[m], obs_ov[m], exp_r[m], exp_thr[m], exp_ov[m]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_multiply();
      test_signed_unsigned();
      test_accumulate_clear();
      test_overflow();
      test_interleave();
      test_reset_mid_accumulation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
